// File: rtl/pwm_capture.sv
// pwm_capture: measures the period and high time of an external PWM signal.
//
// The input is brought into the clk domain through a two-flop synchronizer
// (s1 -> s2) and delayed once more (s3) so that a rising edge is seen as
// s2 & ~s3. Two saturating counters run between rising edges; at each rising
// edge after the first, their values are latched as one measurement and a
// one-cycle strobe is raised.
//
// Ports:
//   clk          system clock, all logic on posedge
//   rst_n        synchronous active-low reset
//   pwm_in       asynchronous PWM input
//   period_out   last measured period (rising edge to rising edge), clk cycles
//   duty_out     last measured high time, clk cycles
//   sample_valid one-cycle pulse when period_out/duty_out update
//   locked       high while consecutive periods are being measured
//   lost         high after a timeout, cleared by the next rising edge
//   dbg_state_o  current FSM state (0 WAIT, 1 FIRST, 2 RUN)
//
// Handshake: sample_valid is a pure strobe with no ready; a consumer must
// capture period_out/duty_out in the cycle sample_valid is high. The values
// stay stable until the next strobe.
module pwm_capture #(
  parameter int WIDTH   = 26,
  parameter int TIMEOUT = 4000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] period_out,
  output logic [WIDTH-1:0] duty_out,
  output logic             sample_valid,
  output logic             locked,
  output logic             lost,
  output logic [1:0]       dbg_state_o
);

  localparam logic [WIDTH-1:0] TMO = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_FIRST = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic [WIDTH-1:0] per_cnt_q, per_cnt_d;
  logic [WIDTH-1:0] hi_cnt_q, hi_cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             lost_q, lost_d;

  logic rise;
  logic timeout;

  assign rise    = s2_q & ~s3_q;
  // A rise in the same cycle the period counter saturates wins over timeout.
  assign timeout = (per_cnt_q == TMO) & ~rise;

  // Counters: both load 1 on a rise (the rise cycle is itself high), then
  // count up and hold at TMO so they never wrap.
  always_comb begin
    per_cnt_d = per_cnt_q;
    hi_cnt_d  = hi_cnt_q;
    if (rise) begin
      per_cnt_d = ONE;
      hi_cnt_d  = ONE;
    end else begin
      if (per_cnt_q != TMO) per_cnt_d = per_cnt_q + ONE;
      if (s2_q && (hi_cnt_q != TMO)) hi_cnt_d = hi_cnt_q + ONE;
    end
  end

  // State register and all datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_WAIT;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      per_cnt_q <= '0;
      hi_cnt_q  <= '0;
      period_q  <= '0;
      duty_q    <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      s1_q      <= pwm_in;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      per_cnt_q <= per_cnt_d;
      hi_cnt_q  <= hi_cnt_d;
      period_q  <= period_d;
      duty_q    <= duty_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
      lost_q    <= lost_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_WAIT:  if (rise) state_d = ST_FIRST;
      ST_FIRST: begin
        if (rise)         state_d = ST_RUN;
        else if (timeout) state_d = ST_WAIT;
      end
      ST_RUN:   if (timeout) state_d = ST_WAIT;
      default:  state_d = ST_WAIT;
    endcase
  end

  // Output logic: measurements are only latched on a rise that closes a
  // full period, so the outputs hold through timeout and WAIT.
  always_comb begin
    period_d = period_q;
    duty_d   = duty_q;
    valid_d  = 1'b0;
    locked_d = locked_q;
    lost_d   = lost_q;
    unique case (state_q)
      ST_WAIT: begin
        if (rise) lost_d = 1'b0;
      end
      ST_FIRST, ST_RUN: begin
        if (rise) begin
          period_d = per_cnt_q;
          duty_d   = hi_cnt_q;
          valid_d  = 1'b1;
          locked_d = 1'b1;
          lost_d   = 1'b0;
        end else if (timeout) begin
          locked_d = 1'b0;
          lost_d   = 1'b1;
        end
      end
      default: begin
        locked_d = 1'b0;
      end
    endcase
  end

  assign period_out   = period_q;
  assign duty_out     = duty_q;
  assign sample_valid = valid_q;
  assign locked       = locked_q;
  assign lost         = lost_q;
  assign dbg_state_o  = state_q;

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
Receive-side counterpart of the on-board PWM generator. It samples an external PWM input and measures the period and high time of each cycle in clk cycles. Each completed period produces one measurement pair and a 1-cycle strobe. Used for loopback self-test of the PWM driver and to read external PWM or servo-style command signals into the control logic.

Parameters:
WIDTH, 26, width of counters and measurement outputs (matches the PWM generator duty width)
TIMEOUT, 4000000, cycles without a rising edge before the signal is declared lost; must be > max expected period and < 2^WIDTH

Ports:
clk  input  1  system clock; all logic on posedge
rst_n  input  1  synchronous active-low reset
pwm_in  input  1  asynchronous PWM input
period_out  output  WIDTH  last measured period, clk cycles, rising edge to rising edge
duty_out  output  WIDTH  last measured high time, clk cycles
sample_valid  output  1  1-cycle pulse when period_out/duty_out update
locked  output  1  high while consecutive periods are being measured
lost  output  1  high after a timeout; cleared on the next detected rising edge

Behaviour:
- Reset (rst_n=0 at a posedge): all outputs 0, counters 0, sync flops 0, state WAIT. Reset wins over every other event, including mid-measurement.
- Input conditioning: 2-FF synchronizer s1->s2, plus a delay flop s3.
- rise = s2 & ~s3. There is no glitch filter: a 1-cycle high pulse that survives synchronization counts as an edge.
- Counters:
  - per_cnt: on rise, loads 1; otherwise increments, saturating at TIMEOUT.
  - hi_cnt: on rise, loads 1; otherwise increments when s2=1, saturating at TIMEOUT.
  - Result for input period P with H high cycles: at the next rise, per_cnt=P and hi_cnt=H.
- States:
  - WAIT: wait for the first rise. On rise -> FIRST (counters load 1, no strobe).
  - FIRST: first period in progress. On rise -> RUN; latch period_out<=per_cnt, duty_out<=hi_cnt; sample_valid=1; locked<=1; lost<=0.
  - RUN: on each rise, latch period_out and duty_out, pulse sample_valid, reload counters.
  - Timeout (FIRST or RUN): per_cnt==TIMEOUT with no rise that cycle -> WAIT; locked<=0; lost<=1; no strobe.
- Output hold: period_out and duty_out keep their last values through timeout and WAIT.
- Simultaneous per_cnt==TIMEOUT and rise: the rise wins. A normal measurement is produced with period_out=TIMEOUT.
- Constant-low and constant-high inputs (0% / 100% duty) have no rises, so both end in timeout (lost=1).
- lost:
  - Set only by timeout.
  - Cleared on the first rise after a timeout (entry to FIRST).
  - Must be 0 at reset.
- Latency: pwm_in high sampled at posedge k -> rise visible after posedge k+1 -> outputs and sample_valid registered at posedge k+2. sample_valid is high for exactly one cycle.
- Arithmetic: unsigned, WIDTH bits, no wrap (saturation guaranteed by TIMEOUT < 2^WIDTH). duty_out <= period_out always.

Test Plan:
1. Reset with pwm_in toggling, rst_n=0 for 5 cycles -> all outputs 0, no sample_valid. After release, the first rise gives no strobe and locked=0.
2. TIMEOUT=1000; input period 100, high 25, run for 5 periods:
   - first strobe only at the second rise;
   - every strobe gives period_out=100, duty_out=25;
   - strobes exactly 100 cycles apart;
   - locked=1, lost=0.
3. Loopback from the PWM generator (rollover 2000000, duty_in=50000), default TIMEOUT -> period_out=2000001, duty_out=50000 on every strobe.
4. TIMEOUT=1000, locked on period 100; hold pwm_in low:
   - exactly 1000 cycles after the last rise: locked=0, lost=1, no strobe;
   - period_out/duty_out hold 100/25.
   Resume toggling -> lost clears at the first rise; new strobe after one further period. Repeat holding pwm_in high -> same result.
5. TIMEOUT=200; drive a rise exactly when per_cnt reaches 200 -> strobe with period_out=200, no timeout, locked stays 1.
6. Mid-period reset: locked on period 100, assert rst_n=0 for 1 cycle at cycle 50 of a period -> all outputs 0, state WAIT. Two further rises are needed before the next strobe, and it reports period 100.
